// File: rtl/npc_pkg.sv
// Shared writeback types and datapath constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package npc_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    // One candidate write into the register file.
    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bits for registers with an outstanding long-latency write, plus decode lookup.
// Latency: set/clear visible one cycle later; lookup is combinational on current state.
// Backpressure: none; set and clear are accepted every cycle, set wins on the same rd.
module wb_scoreboard
    import npc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_vld_i,
    input  logic [AW-1:0] set_rd_i,
    input  logic          clr_vld_i,
    input  logic [AW-1:0] clr_rd_i,
    input  logic [AW-1:0] chk_rs1_i,
    input  logic [AW-1:0] chk_rs2_i,
    output logic          chk_busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Apply the clear first so that a same-cycle re-issue of the retiring rd keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_vld_i) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register; reset drops every outstanding entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A retiring write in this same cycle is not seen here: decode takes one extra stall.
    assign chk_busy_o = busy_q[chk_rs1_i] | busy_q[chk_rs2_i];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the pipeline and long-latency unit results into the GPR write port.
// Latency: 1 cycle from grant to rf_* outputs; stall_req is registered.
// Backpressure: pipeline is never stalled; LU is held off via lu_ready, starvation raises stall_req.
module wb_arbiter
    import npc_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic [AW-1:0]   pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [AW-1:0]   lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   chk_rs1,
    input  logic [AW-1:0]   chk_rs2,
    output logic            chk_busy,
    output logic            stall_req,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int            SW          = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    logic          pipe_ok;
    logic          lu_fire;
    logic          lu_blocked;
    wb_req_t       grant;
    wb_req_t       out_q;
    wb_req_t       out_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          stall_q;
    logic          stall_d;

    // Pipeline writes to x0 are discarded up front so they never block the LU.
    always_comb begin
        pipe_ok    = pipe_valid && (pipe_rd != '0);
        lu_ready   = !pipe_ok;
        lu_fire    = lu_valid && lu_ready;
        lu_blocked = lu_valid && !lu_ready;
    end

    // Pick the winner; an LU result for x0 still retires but produces no write.
    always_comb begin
        grant = '0;
        if (pipe_ok) begin
            grant = '{valid: 1'b1, rd: pipe_rd, data: pipe_data};
        end else if (lu_fire && (lu_rd != '0)) begin
            grant = '{valid: 1'b1, rd: lu_rd, data: lu_data};
        end
    end

    // Address and data hold their last written value on idle cycles.
    always_comb begin
        out_d       = out_q;
        out_d.valid = grant.valid;
        if (grant.valid) begin
            out_d = grant;
        end
    end

    // Count consecutive blocked LU cycles; the last one emits a one-cycle stall and restarts.
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (lu_blocked) begin
            if (starve_q == STARVE_LAST) begin
                stall_d = 1'b1;
            end else begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Output and starvation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign rf_wen    = out_q.valid;
    assign rf_waddr  = out_q.rd;
    assign rf_wdata  = out_q.data;
    assign stall_req = stall_q;

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_vld_i  (iss_valid),
        .set_rd_i   (iss_rd),
        .clr_vld_i  (lu_fire),
        .clr_rd_i   (lu_rd),
        .chk_rs1_i  (chk_rs1),
        .chk_rs2_i  (chk_rs2),
        .chk_busy_o (chk_busy)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by constrained-random traffic.
// Latency: expected register outputs are queued one cycle ahead of the DUT.
// Backpressure: stimulus obeys the LU hold rule and the post-stall pipeline bubble.
module tb_wb_arbiter;
    import npc_pkg::*;

    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_valid;
    logic [AW-1:0]   pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            lu_valid;
    logic            lu_ready;
    logic [AW-1:0]   lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic            chk_busy;
    logic            stall_req;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    always #5 clk = ~clk;

    wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_busy   (chk_busy),
        .stall_req  (stall_req),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected registered outputs for one cycle, tagged with the cycle they must appear in.
    typedef struct {
        int              due;
        logic            wen;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            stall;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    // Reference model state: what the register file port and decode should observe.
    bit              busy_m[NREG];
    int              blocked_run = 0;
    logic [AW-1:0]   hold_addr   = '0;
    logic [XLEN-1:0] hold_data   = '0;
    bit              stall_now   = 1'b0;
    bit              lu_pend     = 1'b0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare the registered outputs against the queued expectation for this cycle.
    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].due == cyc) begin
            mon_e = expq.pop_front();
            chk("rf_wen",    XLEN'(rf_wen),    XLEN'(mon_e.wen));
            chk("rf_waddr",  XLEN'(rf_waddr),  XLEN'(mon_e.addr));
            chk("rf_wdata",  rf_wdata,         mon_e.data);
            chk("stall_req", XLEN'(stall_req), XLEN'(mon_e.stall));
        end
    end

    task automatic idle();
        pipe_valid = 1'b0;
        lu_valid   = 1'b0;
        iss_valid  = 1'b0;
        chk_rs1    = '0;
        chk_rs2    = '0;
    endtask

    // One clock of stimulus: check combinational outputs, advance the model, queue expectations.
    task automatic cycle();
        exp_t e;
        bit   pipe_ok;
        bit   fire;
        @(negedge clk);
        pipe_ok = pipe_valid && (pipe_rd != 0);
        fire    = lu_valid && !pipe_ok;
        chk("lu_ready", XLEN'(lu_ready), XLEN'(!pipe_ok));
        chk("chk_busy", XLEN'(chk_busy), XLEN'(busy_m[chk_rs1] | busy_m[chk_rs2]));
        assert (!(iss_valid && iss_rd != 0 && busy_m[iss_rd] && !(fire && lu_rd == iss_rd)))
            else $error("bench issued to a register that is still busy");
        assert (!(stall_now && pipe_valid && !rst))
            else $error("bench drove the pipeline during the stall bubble");
        e.due   = cyc + 1;
        e.stall = 1'b0;
        if (rst) begin
            foreach (busy_m[i]) busy_m[i] = 1'b0;
            blocked_run = 0;
            hold_addr   = '0;
            hold_data   = '0;
            e.wen       = 1'b0;
        end else begin
            if (pipe_ok) begin
                e.wen = 1'b1; hold_addr = pipe_rd; hold_data = pipe_data;
            end else if (fire && lu_rd != 0) begin
                e.wen = 1'b1; hold_addr = lu_rd; hold_data = lu_data;
            end else begin
                e.wen = 1'b0;
            end
            if (fire) busy_m[lu_rd] = 1'b0;
            if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1'b1;
            if (lu_valid && !fire) begin
                blocked_run++;
                if (blocked_run == STARVE_MAX) begin
                    e.stall     = 1'b1;
                    blocked_run = 0;
                end
            end else begin
                blocked_run = 0;
            end
        end
        e.addr    = hold_addr;
        e.data    = hold_data;
        stall_now = e.stall;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit fire_pred;
        int r;
        rst = 1'b1;
        idle();
        pipe_rd = '0; pipe_data = '0; lu_rd = '0; lu_data = '0; iss_rd = '0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Plain pipeline write.
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hAA;
        cycle();
        idle();
        cycle();

        // Pipeline and LU collide: pipeline first, LU next.
        pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 64'h1234_5678_9ABC_DEF0;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 64'hCAFE_F00D_0000_0007;
        cycle();
        pipe_valid = 1'b0;
        cycle();
        idle();
        cycle();

        // Pipeline write to x0 is dropped and the LU goes through.
        pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 64'hDEAD;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 64'h9999;
        cycle();
        idle();
        cycle();

        // Scoreboard set, lookup, clear, and same-cycle re-issue.
        iss_valid = 1'b1; iss_rd = 5'd12;
        cycle();
        iss_valid = 1'b0; chk_rs1 = 5'd12;
        cycle();
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 64'h0C0C;
        cycle();
        lu_valid = 1'b0;
        cycle();
        iss_valid = 1'b1; iss_rd = 5'd12;
        cycle();
        iss_valid = 1'b1; iss_rd = 5'd12; lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 64'h1212;
        cycle();
        idle(); chk_rs2 = 5'd12;
        cycle();
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 64'h2121;
        cycle();
        idle();
        cycle();

        // Starvation: four blocked cycles, one stall pulse, then the LU is accepted.
        lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 64'h2020_2020;
        for (int i = 0; i < STARVE_MAX; i++) begin
            pipe_valid = 1'b1; pipe_rd = 5'(i + 1); pipe_data = {$urandom, $urandom};
            cycle();
        end
        pipe_valid = 1'b0;
        cycle();
        idle();
        cycle();
        cycle();

        // Reset while the LU is blocked and x4 is busy.
        iss_valid = 1'b1; iss_rd = 5'd4;
        cycle();
        iss_valid = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd6; pipe_data = 64'h6666;
        lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 64'h8888;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(); chk_rs1 = 5'd4;
        cycle();
        cycle();

        // Constrained-random traffic.
        lu_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            pipe_valid = !stall_now && ($urandom_range(0, 99) < 55);
            pipe_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            pipe_data  = {$urandom, $urandom};
            if (!lu_pend && $urandom_range(0, 99) < 40) begin
                lu_pend = 1'b1;
                lu_rd   = 5'($urandom_range(0, 31));
                lu_data = {$urandom, $urandom};
            end
            lu_valid  = lu_pend;
            fire_pred = lu_valid && !(pipe_valid && pipe_rd != 0);
            r         = $urandom_range(1, 31);
            iss_rd    = 5'(r);
            iss_valid = ($urandom_range(0, 99) < 30) &&
                        (!busy_m[r] || (fire_pred && lu_rd == 5'(r)));
            chk_rs1   = 5'($urandom_range(0, 31));
            chk_rs2   = 5'($urandom_range(0, 31));
            cycle();
            if (fire_pred || rst) lu_pend = 1'b0;
        end
        rst = 1'b0;
        idle();
        cycle();

        @(negedge clk);
        #1;
        chk("queue_empty", XLEN'(expq.size()), XLEN'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
